frame_composer: RTL and testbench
=================================

# frame_composer

Parametrised frame composer for the LED-matrix dodge game. It builds each displayed frame from three sources: the playfield bitmap, a hex score sidebar with a fixed "SC" label, and the start and lose screens. Frames are committed only on a frame-boundary tick from the matrix driver, so the scan never sees a torn image. It adds a blinking lose screen and a score-change highlight, and sits between the game FSM and the matrix/VGA driver.

## Interface
- W, 18, matrix width in pixels (x index)
- H, 16, matrix height in pixels (y index); must be ≥ 12
- BOARD_W, 9, playfield columns x = 0..BOARD_W-1; sidebar is x = BOARD_W..W-1
- DIGITS, 2, hex score digits; requires W-BOARD_W ≥ 4*DIGITS+1
- COLOR_W, 24, pixel colour width
- BLINK_FRAMES, 30, frame ticks per lose-screen blink phase (≥ 1)
- FLASH_FRAMES, 15, frame ticks the score is highlighted after it changes (≥ 1)
- BOARD_ON / BOARD_OFF, all-ones / 0, playfield colours for bit 1 / bit 0
- INK / PAPER / HL, 0 / all-ones / 24'hFF0000, glyph, background and highlight colours

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse at each frame boundary
- on  in  1  game running
- done  in  1  player lost
- score  in  4*DIGITS  score value, shown in hex
- board_data  in  [BOARD_W-1:0] x [0:H-1]  playfield rows; bit x of row y is pixel (x,y)
- result  out  [COLOR_W-1:0] x [W-1:0] x [0:H-1]  registered frame, indexed [x][y]
- frame_done  out  1  pulses for one cycle on the edge where result is reloaded

## Operation
- State machine: SPLASH, PLAY, LOST_SHOW, LOST_HIDE. It advances only on clock edges where frame_tick = 1.
- Next state on a tick:
  - If on = 1: PLAY.
  - Else if done = 1: entering from SPLASH or PLAY goes to LOST_SHOW with blink_cnt = 0. Within the lost states, blink_cnt increments each tick. When it reaches BLINK_FRAMES-1 it clears and the state toggles between LOST_SHOW and LOST_HIDE.
  - Else: SPLASH.
- SPLASH image: the package start bitmap. LOST_SHOW image: the package lose bitmap.
- Both bitmaps are 18×16. Bit value 1 draws INK and bit value 0 draws PAPER. Row string MSB maps to x = 0.
- Bitmaps are anchored at (0,0) and cropped to W×H. Pixels outside the bitmap draw PAPER.
- LOST_HIDE image: all PAPER.
- PLAY image:
  - Playfield: board_data bit 1 draws BOARD_ON, bit 0 draws BOARD_OFF.
  - Sidebar background is PAPER.
  - "SC" glyph occupies rows 2..6, anchored at the leftmost sidebar column, and draws INK.
  - Digits are 3×5 package glyphs in rows H-5..H-1. Columns are one gap column, then the most significant digit, a gap, the next digit, and so on.
  - Digit colour is INK, or HL while flash_cnt ≠ 0.
- Score flash:
  - score_q is loaded on every tick while the next state is PLAY.
  - On a tick where the next state is PLAY and score ≠ score_q, flash_cnt is set to FLASH_FRAMES.
  - Otherwise flash_cnt decrements on each tick while nonzero.
  - Entering PLAY from another state loads score_q and does not flash.
- The image for the next state is composed combinationally and loaded into result on the tick edge.

## Timing
- Reset: state = SPLASH, result = SPLASH image, blink_cnt = 0, flash_cnt = 0, score_q = 0, frame_done = 0.
- Reset mid-frame or mid-blink takes effect at that edge, independent of frame_tick.
- Latency: inputs sampled at a tick edge appear on result immediately after that edge, with frame_done = 1 for that cycle.
- Between ticks: result, state and counters hold. Input changes between ticks are not observed.
- on and done both high: on wins (PLAY).
- Score change on the same tick as entry into PLAY: no flash.
- A second score change during a flash reloads flash_cnt to FLASH_FRAMES.
- BLINK_FRAMES = 1: phase toggles on every tick.

## Structure
- Package frame_composer_pkg holds:
  - the start and lose bitmaps;
  - the "SC" glyph;
  - the 16-entry 3×5 hex glyph ROM (0-9, A-F);
  - the state enum;
  - default colour constants.
- Sub-module hex_glyph: maps a 4-bit value to a 5×3 glyph. One instance per digit.

## Test plan
- Reset asserted mid-lose-blink → next edge: result = SPLASH image, frame_done = 0, state = SPLASH.
- on = 1, score = 8'h2B, row 0 of board_data = 9'h001, then tick → pixel (0,0) = BOARD_ON. The digit area shows glyphs "2" and "B" in INK (no flash on PLAY entry). frame_done pulses once.
- In PLAY, score 8'h2B → 8'h2C, then tick → digits in HL. They stay in HL for 15 ticks; the 16th tick returns them to INK. Without ticks, result stays unchanged.
- on = 0, done = 1 from PLAY, BLINK_FRAMES = 3 → ticks 1-3 show LOST_SHOW and ticks 4-6 show all PAPER, repeating.
- on = 1 and done = 1 together → PLAY. Then on = 0, done = 0 → SPLASH on the next tick.
- Parameter override W = 22, BOARD_W = 9, DIGITS = 3, score = 12'hF05 → sidebar shows "F05". Bitmap columns x ≥ 18 draw PAPER.

Source files
------------

// File: rtl/frame_composer_pkg.sv
// Shared constants for the LED-matrix frame composer: the start and lose screen
// bitmaps, the "SC" sidebar label, the 3x5 hex digit font, the display state
// enum and the default colours of the 24-bit panel.
package frame_composer_pkg;

  typedef enum logic [1:0] {
    StSplash,
    StPlay,
    StLostShow,
    StLostHide
  } state_e;

  // Full-screen bitmaps. Row string MSB is x = 0; bit 1 draws ink.
  localparam int unsigned BmpW = 18;
  localparam int unsigned BmpH = 16;

  localparam logic [BmpW-1:0] StartBmp [BmpH] = '{
    18'b111111_111111_111111,
    18'b100000_000000_000001,
    18'b100000_000000_000001,
    18'b100000_110000_000001,
    18'b100000_111000_000001,
    18'b100000_111100_000001,
    18'b100000_111110_000001,
    18'b100000_111111_000001,
    18'b100000_111111_000001,
    18'b100000_111110_000001,
    18'b100000_111100_000001,
    18'b100000_111000_000001,
    18'b100000_110000_000001,
    18'b100000_000000_000001,
    18'b100000_000000_000001,
    18'b111111_111111_111111
  };

  localparam logic [BmpW-1:0] LoseBmp [BmpH] = '{
    18'b110000_000000_000011,
    18'b011000_000000_000110,
    18'b001100_000000_001100,
    18'b000110_000000_011000,
    18'b000011_000000_110000,
    18'b000001_100001_100000,
    18'b000000_110011_000000,
    18'b000000_011110_000000,
    18'b000000_011110_000000,
    18'b000000_110011_000000,
    18'b000001_100001_100000,
    18'b000011_000000_110000,
    18'b000110_000000_011000,
    18'b001100_000000_001100,
    18'b011000_000000_000110,
    18'b110000_000000_000011
  };

  // "SC" label: two 3-wide letters with a one-column gap, MSB leftmost.
  localparam int unsigned ScW   = 7;
  localparam int unsigned ScH   = 5;
  localparam int unsigned ScRow = 2;

  localparam logic [ScW-1:0] ScGlyph [ScH] = '{
    7'b111_0_111,
    7'b100_0_100,
    7'b111_0_100,
    7'b001_0_100,
    7'b111_0_111
  };

  // Hex font: five 3-bit rows packed row 0 first (bits 14:12), MSB leftmost.
  localparam logic [14:0] HexFont [16] = '{
    15'b111_101_101_101_111,  // 0
    15'b010_110_010_010_111,  // 1
    15'b111_001_111_100_111,  // 2
    15'b111_001_111_001_111,  // 3
    15'b101_101_111_001_001,  // 4
    15'b111_100_111_001_111,  // 5
    15'b111_100_111_101_111,  // 6
    15'b111_001_001_001_001,  // 7
    15'b111_101_111_101_111,  // 8
    15'b111_101_111_001_111,  // 9
    15'b010_101_111_101_101,  // A
    15'b110_101_110_101_110,  // B
    15'b111_100_100_100_111,  // C
    15'b110_101_101_101_110,  // D
    15'b111_100_111_100_111,  // E
    15'b111_100_111_100_100   // F
  };

  localparam logic [23:0] DefInk      = 24'h000000;
  localparam logic [23:0] DefPaper    = 24'hFFFFFF;
  localparam logic [23:0] DefHl       = 24'hFF0000;
  localparam logic [23:0] DefBoardOn  = 24'hFFFFFF;
  localparam logic [23:0] DefBoardOff = 24'h000000;

endpackage

// File: rtl/frame_composer_hex_glyph.sv
// hex_glyph: looks up the 3x5 glyph for one hex digit.
//   value_i  digit value 0..15
//   glyph_o  glyph_o[row][col]; row 0 is the top row, col 2 the leftmost column
module hex_glyph
  import frame_composer_pkg::*;
(
  input  logic [3:0]      value_i,
  output logic [4:0][2:0] glyph_o
);

  logic [14:0] font_bits;

  assign font_bits = HexFont[value_i];

  for (genvar r = 0; r < 5; r++) begin : g_row
    assign glyph_o[r] = font_bits[14-3*r -: 3];
  end

endmodule

// File: rtl/frame_composer.sv
// frame_composer: builds each LED-matrix frame from the playfield, a hex score
// sidebar and the start/lose screens, and commits it only on frame_tick so the
// scan never sees a torn image.
//   clk_i         system clock
//   reset_i       synchronous active-high reset
//   frame_tick_i  one-cycle pulse at each frame boundary
//   on_i          game running
//   done_i        player lost
//   score_i       score, shown as DIGITS hex digits
//   board_data_i  playfield rows; bit x of row y is pixel (x,y)
//   result_o      registered frame, indexed [x][y]
//   frame_done_o  high for the cycle after result_o is reloaded
module frame_composer
  import frame_composer_pkg::*;
#(
  parameter int unsigned          W            = 18,
  parameter int unsigned          H            = 16,
  parameter int unsigned          BOARD_W      = 9,
  parameter int unsigned          DIGITS       = 2,
  parameter int unsigned          COLOR_W      = 24,
  parameter int unsigned          BLINK_FRAMES = 30,
  parameter int unsigned          FLASH_FRAMES = 15,
  parameter logic [COLOR_W-1:0]   BOARD_ON     = '1,
  parameter logic [COLOR_W-1:0]   BOARD_OFF    = '0,
  parameter logic [COLOR_W-1:0]   INK          = '0,
  parameter logic [COLOR_W-1:0]   PAPER        = '1,
  parameter logic [COLOR_W-1:0]   HL           = COLOR_W'(DefHl)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                frame_tick_i,
  input  logic                on_i,
  input  logic                done_i,
  input  logic [4*DIGITS-1:0] score_i,
  input  logic [BOARD_W-1:0]  board_data_i [0:H-1],
  output logic [COLOR_W-1:0]  result_o     [W-1:0][0:H-1],
  output logic                frame_done_o
);

  localparam int unsigned ScoreW = 4 * DIGITS;
  localparam int unsigned BlinkW = $clog2(BLINK_FRAMES + 1);
  localparam int unsigned FlashW = $clog2(FLASH_FRAMES + 1);
  localparam int unsigned DigRow = H - 5;

  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_FRAMES - 1);
  localparam logic [FlashW-1:0] FlashInit = FlashW'(FLASH_FRAMES);

  state_e              state_q, state_d;
  logic [BlinkW-1:0]   blink_q, blink_d;
  logic [FlashW-1:0]   flash_q, flash_d;
  logic [ScoreW-1:0]   score_q, score_d;
  logic                frame_done_q;
  logic [COLOR_W-1:0]  result_q [W-1:0][0:H-1];
  logic [COLOR_W-1:0]  img      [W-1:0][0:H-1];

  // State register. Reset reloads the frame with the splash image at once.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StSplash;
      blink_q      <= '0;
      flash_q      <= '0;
      score_q      <= '0;
      frame_done_q <= 1'b0;
      result_q     <= img;
    end else begin
      frame_done_q <= frame_tick_i;
      if (frame_tick_i) begin
        state_q  <= state_d;
        blink_q  <= blink_d;
        flash_q  <= flash_d;
        score_q  <= score_d;
        result_q <= img;
      end
    end
  end

  // Next-state logic; only committed on a tick.
  always_comb begin
    state_d = state_q;
    blink_d = blink_q;
    flash_d = flash_q;
    score_d = score_q;

    if (on_i) begin
      state_d = StPlay;
      blink_d = '0;
    end else if (done_i) begin
      unique case (state_q)
        StSplash, StPlay: begin
          state_d = StLostShow;
          blink_d = '0;
        end
        StLostShow, StLostHide: begin
          if (blink_q == BlinkLast) begin
            blink_d = '0;
            state_d = (state_q == StLostShow) ? StLostHide : StLostShow;
          end else begin
            blink_d = blink_q + BlinkW'(1);
          end
        end
      endcase
    end else begin
      state_d = StSplash;
      blink_d = '0;
    end

    // Only a change seen while already playing flashes; entry just loads the score.
    if (state_d == StPlay && state_q == StPlay && score_i != score_q) begin
      flash_d = FlashInit;
    end else if (flash_q != '0) begin
      flash_d = flash_q - FlashW'(1);
    end

    if (state_d == StPlay) begin
      score_d = score_i;
    end
  end

  // Output composition: image for the state being entered (splash under reset).
  state_e             img_state;
  logic [COLOR_W-1:0] digit_color;
  logic [4:0][2:0]    glyph_bits [DIGITS];

  assign img_state   = reset_i ? StSplash : state_d;
  assign digit_color = (flash_d != '0) ? HL : INK;

  for (genvar d = 0; d < DIGITS; d++) begin : g_digit_rom
    hex_glyph u_hex_glyph (
      .value_i (score_d[4*(DIGITS-1-d) +: 4]),
      .glyph_o (glyph_bits[d])
    );
  end

  for (genvar gx = 0; gx < W; gx++) begin : g_col
    for (genvar gy = 0; gy < H; gy++) begin : g_row
      logic               start_bit;
      logic               lose_bit;
      logic [COLOR_W-1:0] play_px;

      if (gx < BmpW && gy < BmpH) begin : g_bmp
        assign start_bit = StartBmp[gy][BmpW-1-gx];
        assign lose_bit  = LoseBmp[gy][BmpW-1-gx];
      end else begin : g_crop
        assign start_bit = 1'b0;
        assign lose_bit  = 1'b0;
      end

      if (gx < BOARD_W) begin : g_board
        assign play_px = board_data_i[gy][gx] ? BOARD_ON : BOARD_OFF;
      end else if (gy >= ScRow && gy < ScRow + ScH && gx - BOARD_W < ScW) begin : g_label
        assign play_px = ScGlyph[gy-ScRow][ScW-1-(gx-BOARD_W)] ? INK : PAPER;
      end else if (gy >= DigRow && gx - BOARD_W >= 1 && (gx - BOARD_W - 1) % 4 < 3 &&
                   (gx - BOARD_W - 1) / 4 < DIGITS) begin : g_digit
        // Each digit takes a 4-column slot: gap column first, then 3 glyph columns.
        localparam int Col = gx - BOARD_W - 1;
        assign play_px = glyph_bits[Col/4][gy-DigRow][2-Col%4] ? digit_color : PAPER;
      end else begin : g_paper
        assign play_px = PAPER;
      end

      assign img[gx][gy] = (img_state == StPlay)     ? play_px :
                           (img_state == StSplash)   ? (start_bit ? INK : PAPER) :
                           (img_state == StLostShow) ? (lose_bit  ? INK : PAPER) :
                                                       PAPER;
    end
  end

  assign result_o     = result_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_frame_composer.sv
module tb_frame_composer;

  localparam int SPL = 0;
  localparam int PLY = 1;
  localparam int SHW = 2;
  localparam int HID = 3;

  localparam logic [23:0] C_INK   = 24'h000000;
  localparam logic [23:0] C_PAPER = 24'hFFFFFF;
  localparam logic [23:0] C_HL    = 24'hFF0000;
  localparam logic [23:0] C_ON    = 24'hFFFFFF;
  localparam logic [23:0] C_OFF   = 24'h000000;

  localparam logic [17:0] TB_START [16] = '{
    18'b111111_111111_111111, 18'b100000_000000_000001, 18'b100000_000000_000001,
    18'b100000_110000_000001, 18'b100000_111000_000001, 18'b100000_111100_000001,
    18'b100000_111110_000001, 18'b100000_111111_000001, 18'b100000_111111_000001,
    18'b100000_111110_000001, 18'b100000_111100_000001, 18'b100000_111000_000001,
    18'b100000_110000_000001, 18'b100000_000000_000001, 18'b100000_000000_000001,
    18'b111111_111111_111111
  };
  localparam logic [17:0] TB_LOSE [16] = '{
    18'b110000_000000_000011, 18'b011000_000000_000110, 18'b001100_000000_001100,
    18'b000110_000000_011000, 18'b000011_000000_110000, 18'b000001_100001_100000,
    18'b000000_110011_000000, 18'b000000_011110_000000, 18'b000000_011110_000000,
    18'b000000_110011_000000, 18'b000001_100001_100000, 18'b000011_000000_110000,
    18'b000110_000000_011000, 18'b001100_000000_001100, 18'b011000_000000_000110,
    18'b110000_000000_000011
  };
  localparam logic [6:0] TB_SC [5] = '{
    7'b111_0_111, 7'b100_0_100, 7'b111_0_100, 7'b001_0_100, 7'b111_0_111
  };
  localparam logic [14:0] TB_FONT [16] = '{
    15'b111_101_101_101_111, 15'b010_110_010_010_111, 15'b111_001_111_100_111,
    15'b111_001_111_001_111, 15'b101_101_111_001_001, 15'b111_100_111_001_111,
    15'b111_100_111_101_111, 15'b111_001_001_001_001, 15'b111_101_111_101_111,
    15'b111_101_111_001_111, 15'b010_101_111_101_101, 15'b110_101_110_101_110,
    15'b111_100_100_100_111, 15'b110_101_101_101_110, 15'b111_100_111_100_111,
    15'b111_100_111_100_100
  };

  typedef struct {
    logic [23:0] a [18][16];
    logic [23:0] b [22][16];
  } frame_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        on = 1'b0;
  logic        done = 1'b0;
  logic [7:0]  score_a = '0;
  logic [11:0] score_b = '0;
  logic [8:0]  board [0:15];
  logic [23:0] result_a [17:0][0:15];
  logic [23:0] result_b [21:0][0:15];
  logic        fd_a, fd_b;

  int n_checks = 0;
  int n_fail = 0;

  frame_t sb [$];
  frame_t last;

  int          ma_st, ma_bl, ma_fl, mb_st, mb_bl, mb_fl;
  logic [11:0] ma_sq, mb_sq;
  bit          mon_tick;

  always #5 clk = ~clk;

  frame_composer #(
    .BLINK_FRAMES (3)
  ) u_dut_a (
    .clk_i        (clk),
    .reset_i      (reset),
    .frame_tick_i (frame_tick),
    .on_i         (on),
    .done_i       (done),
    .score_i      (score_a),
    .board_data_i (board),
    .result_o     (result_a),
    .frame_done_o (fd_a)
  );

  frame_composer #(
    .W            (22),
    .BOARD_W      (9),
    .DIGITS       (3),
    .BLINK_FRAMES (1),
    .FLASH_FRAMES (2)
  ) u_dut_b (
    .clk_i        (clk),
    .reset_i      (reset),
    .frame_tick_i (frame_tick),
    .on_i         (on),
    .done_i       (done),
    .score_i      (score_b),
    .board_data_i (board),
    .result_o     (result_b),
    .frame_done_o (fd_b)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [23:0] model_px(input int digits, input int st, input int x,
                                           input int y, input logic [8:0] brow,
                                           input logic [11:0] sc, input int fl);
    int          sx, c, d;
    logic [3:0]  v;
    logic [17:0] row;
    case (st)
      SPL, SHW: begin
        if (x >= 18) return C_PAPER;
        row = (st == SPL) ? TB_START[y] : TB_LOSE[y];
        return row[17-x] ? C_INK : C_PAPER;
      end
      PLY: begin
        if (x < 9) return brow[x] ? C_ON : C_OFF;
        sx = x - 9;
        if (y >= 2 && y <= 6 && sx < 7) return TB_SC[y-2][6-sx] ? C_INK : C_PAPER;
        if (y >= 11 && sx >= 1) begin
          c = sx - 1;
          d = c / 4;
          if (c % 4 < 3 && d < digits) begin
            v = sc[4*(digits-1-d) +: 4];
            if (TB_FONT[v][14 - 3*(y-11) - c%4]) return (fl != 0) ? C_HL : C_INK;
          end
        end
        return C_PAPER;
      end
      default: return C_PAPER;
    endcase
  endfunction

  task automatic model_step(input int bf, input int ff, input logic [11:0] sc,
                            inout int st, inout int bl, inout int fl,
                            inout logic [11:0] sq);
    int nst, nbl;
    nst = st;
    nbl = bl;
    if (on) begin
      nst = PLY;
      nbl = 0;
    end else if (done) begin
      if (st == SPL || st == PLY) begin
        nst = SHW;
        nbl = 0;
      end else if (bl == bf - 1) begin
        nbl = 0;
        nst = (st == SHW) ? HID : SHW;
      end else begin
        nbl = bl + 1;
      end
    end else begin
      nst = SPL;
      nbl = 0;
    end
    if (nst == PLY && st == PLY && sc != sq) fl = ff;
    else if (fl > 0) fl--;
    if (nst == PLY) sq = sc;
    st = nst;
    bl = nbl;
  endtask

  task automatic build(output frame_t f);
    for (int x = 0; x < 18; x++)
      for (int y = 0; y < 16; y++)
        f.a[x][y] = model_px(2, ma_st, x, y, board[y], ma_sq, ma_fl);
    for (int x = 0; x < 22; x++)
      for (int y = 0; y < 16; y++)
        f.b[x][y] = model_px(3, mb_st, x, y, board[y], mb_sq, mb_fl);
  endtask

  // One comparison per DUT per frame, reported at the first differing pixel.
  task automatic cmp_frame(input string tag, input frame_t e);
    int fx, fy;
    bit found;
    fx = 0; fy = 0; found = 0;
    for (int x = 0; x < 18; x++)
      for (int y = 0; y < 16; y++)
        if (!found && result_a[x][y] !== e.a[x][y]) begin
          fx = x; fy = y; found = 1;
        end
    check($sformatf("%s A px(%0d,%0d)", tag, fx, fy), result_a[fx][fy], e.a[fx][fy]);
    fx = 0; fy = 0; found = 0;
    for (int x = 0; x < 22; x++)
      for (int y = 0; y < 16; y++)
        if (!found && result_b[x][y] !== e.b[x][y]) begin
          fx = x; fy = y; found = 1;
        end
    check($sformatf("%s B px(%0d,%0d)", tag, fx, fy), result_b[fx][fy], e.b[fx][fy]);
  endtask

  task automatic do_tick();
    frame_t e;
    frame_tick = 1'b1;
    model_step(3, 15, {4'h0, score_a}, ma_st, ma_bl, ma_fl, ma_sq);
    model_step(1, 2, score_b, mb_st, mb_bl, mb_fl, mb_sq);
    build(e);
    sb.push_back(e);
    last = e;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    frame_t e;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ma_st = SPL; ma_bl = 0; ma_fl = 0; ma_sq = '0;
    mb_st = SPL; mb_bl = 0; mb_fl = 0; mb_sq = '0;
    build(e);
    last = e;
    cmp_frame("reset", e);
  endtask

  task automatic rand_board();
    for (int y = 0; y < 16; y++) board[y] = 9'($urandom);
  endtask

  // Scoreboard consumer: every frame_done pops one expected frame.
  always @(posedge clk) begin
    mon_tick = frame_tick && !reset;
    #1;
    check("frame_done A", fd_a, mon_tick);
    check("frame_done B", fd_b, mon_tick);
    if (mon_tick) begin
      check("sb nonempty", sb.size() != 0, 1'b1);
      if (sb.size() != 0) cmp_frame("tick", sb.pop_front());
    end
  end

  initial begin
    for (int y = 0; y < 16; y++) board[y] = '0;
    @(negedge clk);
    do_reset();
    check("B crop x=19", result_b[19][3], C_PAPER);

    do_tick();  // stays in splash

    // Enter PLAY: no flash on entry.
    on = 1'b1; score_a = 8'h2B; score_b = 12'hF05;
    rand_board();
    board[0] = 9'h001;
    do_tick();
    check("px00 board_on", result_a[0][0], C_ON);
    check("digit 2 ink", result_a[10][11], C_INK);
    check("B digit F ink", result_b[10][11], C_INK);
    check("B digit 5 ink", result_b[18][11], C_INK);

    // Inputs changing between ticks are not observed.
    score_a = 8'h77; score_b = 12'h123; on = 1'b0; done = 1'b1; rand_board();
    repeat (4) @(negedge clk);
    cmp_frame("hold", last);
    score_a = 8'h2B; score_b = 12'hF05; on = 1'b1; done = 1'b0;

    // Score change: 15 ticks highlighted, 16th back to ink.
    score_a = 8'h2C; score_b = 12'hF06;
    do_tick();
    check("digit hl", result_a[10][11], C_HL);
    for (int i = 2; i <= 16; i++) begin
      rand_board();
      do_tick();
      if (i == 15) check("digit hl tick15", result_a[10][11], C_HL);
      if (i == 16) check("digit ink tick16", result_a[10][11], C_INK);
    end

    // Second change during a flash reloads the counter.
    score_a = 8'h31; do_tick();
    repeat (3) do_tick();
    score_a = 8'h32; do_tick();
    repeat (14) do_tick();
    check("reloaded hl", result_a[10][11], C_HL);
    do_tick();

    // Lose blink from PLAY.
    on = 1'b0; done = 1'b1;
    repeat (8) do_tick();

    // Reset mid-blink, no tick.
    do_reset();

    // Lost from splash, then on+done together wins, then back to splash.
    repeat (2) do_tick();
    on = 1'b1; do_tick();
    on = 1'b0; done = 1'b0; do_tick();
    on = 1'b1; score_a = 8'hE0; do_tick();
    on = 1'b0; done = 1'b1; repeat (3) do_tick();

    repeat (2) @(negedge clk);
    check("sb drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
